// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : PC register and fetch sequencing (BOOT/RUN/HALT) with
//             saturating cycle and stall performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2,
    parameter logic [31:0] HALT_INSTR  = 32'hFFFF_FFFF,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWrite,
    input  logic [31:0]      NextAddr,
    input  logic [31:0]      Instr,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    output logic [31:0]      PC,
    output logic             FetchValid,
    output logic             Halted,
    output logic             AlignErr,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0]       c_bootLast = 4'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cntMax   = '1;

    state_t           r_state, w_stateNext;
    logic [3:0]       r_bootCnt, w_bootCntNext;
    logic [31:0]      r_pc, w_pcNext;
    logic             r_alignErr, w_alignErrNext;
    logic [CNT_W-1:0] r_cycleCnt, w_cycleCntNext;
    logic [CNT_W-1:0] r_stallCnt, w_stallCntNext;

    always_comb begin
        w_stateNext    = r_state;
        w_bootCntNext  = r_bootCnt;
        w_pcNext       = r_pc;
        w_alignErrNext = r_alignErr;
        w_cycleCntNext = r_cycleCnt;
        w_stallCntNext = r_stallCnt;

        case (r_state)
            BOOT: begin
                w_bootCntNext = r_bootCnt + 4'd1;
                if (r_bootCnt == c_bootLast) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (r_cycleCnt != c_cntMax) begin
                    w_cycleCntNext = r_cycleCnt + 1'b1;
                end
                // Redirect beats a stall; halt is only honoured on an accepted, unflushed instruction.
                if (BranchTaken) begin
                    w_pcNext = {BranchTarget[31:2], 2'b00};
                    if (BranchTarget[1:0] != 2'b00) begin
                        w_alignErrNext = 1'b1;
                    end
                end else if (!PCWrite) begin
                    if (r_stallCnt != c_cntMax) begin
                        w_stallCntNext = r_stallCnt + 1'b1;
                    end
                end else if (Instr == HALT_INSTR) begin
                    w_stateNext = HALT;
                end else begin
                    w_pcNext = NextAddr;
                end
            end
            HALT: begin
            end
            default: begin
                w_stateNext = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_bootCnt  <= 4'd0;
            r_pc       <= RESET_ADDR;
            r_alignErr <= 1'b0;
            r_cycleCnt <= '0;
            r_stallCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_bootCnt  <= w_bootCntNext;
            r_pc       <= w_pcNext;
            r_alignErr <= w_alignErrNext;
            r_cycleCnt <= w_cycleCntNext;
            r_stallCnt <= w_stallCntNext;
        end
    end

    assign PC         = r_pc;
    assign FetchValid = (r_state == RUN);
    assign Halted     = (r_state == HALT);
    assign AlignErr   = r_alignErr;
    assign CycleCount = r_cycleCnt;
    assign StallCount = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Purpose  : Scoreboard bench for pc_fetch_ctrl against a cycle-level
//             reference model (full-width and 4-bit counter instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam int          BOOT_N = 2;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        PCWrite;
    logic [31:0] NextAddr;
    logic [31:0] Instr;
    logic        BranchTaken;
    logic [31:0] BranchTarget;

    logic [31:0] PC;
    logic        FetchValid, Halted, AlignErr;
    logic [31:0] CycleCount, StallCount;

    logic [31:0] satPc;
    logic        satFv, satHl, satAe;
    logic [3:0]  satCyc, satStl;

    pc_fetch_ctrl #(.BOOT_CYCLES(BOOT_N), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .NextAddr(NextAddr),
        .Instr(Instr), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .PC(PC), .FetchValid(FetchValid), .Halted(Halted), .AlignErr(AlignErr),
        .CycleCount(CycleCount), .StallCount(StallCount)
    );

    pc_fetch_ctrl #(.BOOT_CYCLES(BOOT_N), .CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .NextAddr(NextAddr),
        .Instr(Instr), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .PC(satPc), .FetchValid(satFv), .Halted(satHl), .AlignErr(satAe),
        .CycleCount(satCyc), .StallCount(satStl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          fv;
        bit          hl;
        bit          ae;
        longint      cyc;
        longint      stl;
    } exp_t;

    exp_t q[$];
    event sampleEv;
    int   passCnt  = 0;
    int   totalCnt = 0;

    // Reference model: cycles left in boot, halted flag, architectural state.
    int          mBootLeft;
    bit          mHalted;
    logic [31:0] mPc;
    bit          mAe;
    longint      mCyc, mStl;

    function automatic longint satv(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        mBootLeft = BOOT_N;
        mHalted   = 1'b0;
        mPc       = 32'h0;
        mAe       = 1'b0;
        mCyc      = 0;
        mStl      = 0;
    endtask

    task automatic modelEdge(input bit rn, input bit pcw, input logic [31:0] na,
                             input logic [31:0] ins, input bit br, input logic [31:0] tg);
        if (!rn) begin
            modelReset();
        end else if (mBootLeft > 0) begin
            mBootLeft--;
        end else if (!mHalted) begin
            mCyc++;
            if (br) begin
                mPc = tg & 32'hFFFF_FFFC;
                if (tg % 4 != 0) mAe = 1'b1;
            end else if (!pcw) begin
                mStl++;
            end else if (ins == HALT_W) begin
                mHalted = 1'b1;
            end else begin
                mPc = na;
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.pc  = mPc;
        e.fv  = (mBootLeft == 0) && !mHalted;
        e.hl  = mHalted;
        e.ae  = mAe;
        e.cyc = mCyc;
        e.stl = mStl;
        return e;
    endfunction

    task automatic step(input bit rn, input bit pcw, input logic [31:0] na,
                        input logic [31:0] ins, input bit br, input logic [31:0] tg);
        rst_n        = rn;
        PCWrite      = pcw;
        NextAddr     = na;
        Instr        = ins;
        BranchTaken  = br;
        BranchTarget = tg;
        modelEdge(rn, pcw, na, ins, br, tg);
        q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic go(input bit pcw, input logic [31:0] ins, input bit br, input logic [31:0] tg);
        step(1'b1, pcw, mPc + 32'd4, ins, br, tg);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT_W) v = 32'h0000_0013;
        return v;
    endfunction

    // Monitor: compares after every rising edge, or on demand for async events.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sampleEv);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("PC",         longint'(PC),         longint'(e.pc));
                check("FetchValid", longint'(FetchValid), longint'(e.fv));
                check("Halted",     longint'(Halted),     longint'(e.hl));
                check("AlignErr",   longint'(AlignErr),   longint'(e.ae));
                check("CycleCount", longint'(CycleCount), satv(e.cyc, 32));
                check("StallCount", longint'(StallCount), satv(e.stl, 32));
                check("satPC",      longint'(satPc),      longint'(e.pc));
                check("satHalted",  longint'(satHl),      longint'(e.hl));
                check("satCycle",   longint'(satCyc),     satv(e.cyc, 4));
                check("satStall",   longint'(satStl),     satv(e.stl, 4));
            end
        end
    end

    initial begin
        logic [31:0] na;
        bit          rn;
        modelReset();

        // Reset held, release, boot then sequential fetch 0,4,8
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h4, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'h4, 32'h0, 1'b1, 32'h80);
        for (int i = 0; i < 2; i++) go(1'b1, 32'h13, 1'b0, 32'h0);

        // Stall 3 cycles at PC=8, then resume
        for (int i = 0; i < 3; i++) go(1'b0, HALT_W, 1'b0, 32'h0);
        go(1'b1, 32'h13, 1'b0, 32'h0);

        // Branch over stall, aligned then misaligned
        go(1'b0, 32'h13, 1'b1, 32'h40);
        go(1'b0, 32'h13, 1'b1, 32'h43);
        for (int i = 0; i < 3; i++) go(1'b1, 32'h13, 1'b0, 32'h0);

        // Randomised run without halts
        for (int i = 0; i < 300; i++) begin
            na = ($urandom_range(0, 3) == 0) ? $urandom : mPc + 32'd4;
            step(1'b1, $urandom_range(0, 3) != 0, na, randInstr(),
                 $urandom_range(0, 7) == 0, $urandom);
        end

        // PC wrap at top of address space
        go(1'b1, 32'h13, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 32'h0, 32'h13, 1'b0, 32'h0);

        // Saturate the 4-bit stall counter
        for (int i = 0; i < 20; i++) go(1'b0, 32'h13, 1'b0, 32'h0);

        // Async reset mid-run at PC=0x100
        go(1'b1, 32'h13, 1'b1, 32'h100);
        go(1'b0, 32'h13, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        modelReset();
        q.push_back(snapshot());
        ->sampleEv;
        #2;
        step(1'b0, 1'b1, 32'h4, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'h4, 32'h0, 1'b1, 32'h200);
        go(1'b1, 32'h13, 1'b0, 32'h0);

        // Halt: suppressed by stall and by branch, then taken at PC=0x20
        go(1'b1, 32'h13, 1'b1, 32'h20);
        go(1'b0, HALT_W, 1'b0, 32'h0);
        go(1'b1, HALT_W, 1'b1, 32'h20);
        go(1'b1, HALT_W, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++)
            step(1'b1, $urandom_range(0, 1) != 0, $urandom, $urandom,
                 $urandom_range(0, 1) != 0, $urandom);

        // Random run including halts and occasional resets
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 49) != 0);
            na = ($urandom_range(0, 3) == 0) ? $urandom : mPc + 32'd4;
            step(rn, $urandom_range(0, 3) != 0, na,
                 ($urandom_range(0, 39) == 0) ? HALT_W : randInstr(),
                 $urandom_range(0, 7) == 0, $urandom);
        end

        @(posedge clk);
        #3;
        check("scoreboardDrained", longint'(q.size()), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage directly upstream of the five-stage pipeline core. It owns the PC register that drives the core's instruction address input. It consumes the core's PC+4 result and PCWrite stall signal, and accepts a branch redirect. It sequences boot, run and halt, and keeps stall and cycle performance counters.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
BOOT_CYCLES, 2, cycles PC is held after reset before fetching starts (1..15).
HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that halts fetch.
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
PCWrite  input  1  from core hazard unit; 0 = hold PC (load-use stall).
NextAddr  input  32  PC+4 from core adder.
Instr  input  32  instruction memory output at current PC.
BranchTaken  input  1  redirect request, single-cycle pulse.
BranchTarget  input  32  redirect address.
PC  output  32  current fetch address, drives core instruction address.
FetchValid  output  1  1 when the instruction at PC is a real fetch.
Halted  output  1  1 in HALT state.
AlignErr  output  1  sticky; set when a misaligned BranchTarget was taken.
CycleCount  output  CNT_W  cycles spent in RUN.
StallCount  output  CNT_W  RUN cycles with PC held by PCWrite=0.

Behaviour:
- Reset is asynchronous on rst_n low and overrides everything, including mid-operation. Reset values:
  - PC=RESET_ADDR, state=BOOT, boot counter=0.
  - FetchValid=0, Halted=0, AlignErr=0.
  - CycleCount=0, StallCount=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- States: BOOT, RUN, HALT. FetchValid=1 only in RUN. Halted=1 only in HALT.
- BOOT:
  - PC holds and all inputs are ignored.
  - The boot counter increments each cycle. When it reaches BOOT_CYCLES-1, the next state is RUN.
  - PC becomes valid on the first RUN cycle, BOOT_CYCLES cycles after reset release.
- RUN, evaluated every rising edge, in priority order:
  1. BranchTaken=1: PC <= {BranchTarget[31:2],2'b00}. This applies even if PCWrite=0; the redirect wins over the stall. If BranchTarget[1:0]!=0, AlignErr <= 1 (sticky until reset). Halt detection is suppressed this cycle because the instruction is being flushed.
  2. Else if PCWrite=0: PC holds. StallCount increments. Halt detection is suppressed because the instruction is not yet accepted.
  3. Else if Instr==HALT_INSTR: PC holds and the next state is HALT.
  4. Else: PC <= NextAddr.
- CycleCount increments on every RUN cycle, including the cycle that transitions to HALT.
- Counters saturate at all-ones and do not wrap. A stall cycle at saturation leaves StallCount unchanged.
- PC arithmetic is 32-bit modular. NextAddr=32'h0000_0000 after 32'hFFFF_FFFC is accepted without special handling.
- HALT:
  - PC, counters and AlignErr are frozen. All inputs are ignored.
  - The only exit is reset.
- PC is loaded only in RUN. A BranchTaken pulse in BOOT or HALT is dropped.

Test Plan:
- Reset/boot: BOOT_CYCLES=2, hold rst_n low, release. Required: PC=0 and FetchValid=0 for 2 cycles, then FetchValid=1. With NextAddr=PC+4 and PCWrite=1, PC steps 0,4,8.
- Stall: in RUN at PC=8, drive PCWrite=0 for 3 cycles. Required: PC stays 8 and StallCount goes 0→3. CycleCount keeps incrementing. Then PC=12 one cycle after PCWrite returns to 1.
- Branch over stall: PCWrite=0 with BranchTaken=1 and BranchTarget=32'h40. Required: PC=32'h40 next cycle, StallCount unchanged. Repeat with target 32'h43. Required: PC=32'h40 and AlignErr=1, still 1 after further cycles.
- Halt: Instr=32'hFFFF_FFFF with PCWrite=1 at PC=32'h20. Required: Halted=1 and FetchValid=0 next cycle, PC stays 32'h20. Later BranchTaken and PCWrite toggling change nothing. Same Instr with PCWrite=0 or BranchTaken=1 does not halt.
- Wrap and saturation: preload PC to 32'hFFFF_FFFC, NextAddr=0. Required: PC=0. With CNT_W=4, run 20 stall cycles. Required: StallCount=4'hF and held.
- Async reset mid-run: assert rst_n low between clock edges while in RUN at PC=32'h100 with counters nonzero. Required: outputs return to reset values immediately, with no clock edge needed. Boot sequencing restarts on release.
